operand_stage: RTL and testbench

- Parametrised, registered successor to the combinational operand-select datapath.
- Selects the A operand (an_o) and B operand (am_o) from PC, two register values and an immediate.
- Places the immediate bottom, top or across two instructions (captured low half plus high half).
- Buffers results in a small output FIFO with valid/ready handshakes on both sides. Sits between decode and the ALU.

---
 rtl/opstage_pkg.sv | 35 +++
 rtl/opstage_if.sv | 29 ++
 rtl/opstage_fifo.sv | 64 ++++++
 rtl/operand_stage.sv | 142 ++++++++++++++
 tb/tb_operand_stage.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/opstage_pkg.sv
// Shared types for the registered operand-select stage: source encodings,
// capture/concat hold state and the {an, am} FIFO entry.
package opstage_pkg;

    localparam int XLEN_DEF = 32;

    typedef enum logic [1:0] {
        A_RS1     = 2'd0,
        A_PC      = 2'd1,
        A_ZERO    = 2'd2,
        A_PC_NEXT = 2'd3
    } a_sel_e;

    typedef enum logic [2:0] {
        B_RS2     = 3'd0,
        B_SEXT    = 3'd1,
        B_ZEXT    = 3'd2,
        B_TOP     = 3'd3,
        B_CONCAT  = 3'd4,
        B_CAPTURE = 3'd5,
        B_RSV6    = 3'd6,
        B_RSV7    = 3'd7
    } b_sel_e;

    typedef enum logic {
        H_EMPTY  = 1'b0,
        H_LOADED = 1'b1
    } hold_state_e;

    typedef struct packed {
        logic [XLEN_DEF-1:0] an;
        logic [XLEN_DEF-1:0] am;
    } entry_t;

endpackage

// File: rtl/opstage_if.sv
// Decode-side request and ALU-side result handshake bundle of operand_stage.
interface opstage_if #(
    parameter int XLEN  = 32,
    parameter int IMM_W = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [XLEN-1:0]  pc_i;
    logic [XLEN-1:0]  rs1_i;
    logic [XLEN-1:0]  rs2_i;
    logic [IMM_W-1:0] imm_i;
    logic [1:0]       a_sel;
    logic [2:0]       b_sel;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  an_o;
    logic [XLEN-1:0]  am_o;
    logic             err_o;

    modport slave (
        input  in_valid, pc_i, rs1_i, rs2_i, imm_i, a_sel, b_sel, out_ready,
        output in_ready, out_valid, an_o, am_o, err_o
    );

    modport master (
        output in_valid, pc_i, rs1_i, rs2_i, imm_i, a_sel, b_sel, out_ready,
        input  in_ready, out_valid, an_o, am_o, err_o
    );
endinterface

// File: rtl/opstage_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO with occupancy count, full and empty.
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module opstage_fifo #(
    parameter int  DEPTH = 2,
    parameter int  WIDTH = 64,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A full FIFO refuses pushes even when the head leaves in the same cycle.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/operand_stage.sv
// Registered operand select: A/B muxing, two-instruction immediate hold and an
// output FIFO. Define OPSTAGE_BYPASS_EN for a same-cycle path when the FIFO is empty.
module operand_stage
    import opstage_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int IMM_W     = 16,
    parameter int OUT_DEPTH = 2,
    parameter int PC_STEP   = 4
) (
    input logic      clk,
    input logic      rst_n,
    opstage_if.slave bus
);
    localparam int CW = $clog2(OUT_DEPTH) + 1;

    function automatic logic [XLEN-1:0] sext_imm(input logic signed [IMM_W-1:0] v);
        logic signed [XLEN-1:0] w;
        w = v;
        return w;
    endfunction

    function automatic logic [XLEN-1:0] zext_imm(input logic [IMM_W-1:0] v);
        return XLEN'(v);
    endfunction

    function automatic logic [XLEN-1:0] top_imm(input logic [IMM_W-1:0] v);
        return zext_imm(v) << (XLEN - IMM_W);
    endfunction

    a_sel_e           asel;
    b_sel_e           bsel;
    hold_state_e      hold_q, hold_d;
    logic [IMM_W-1:0] hold_r_q, hold_r_d;
    logic             err_q, err_d;
    logic [IMM_W-1:0] hold_eff;
    logic [XLEN-1:0]  an_c, am_c;
    logic             in_ready_w, accept, is_cap;
    logic             push, pop, out_valid_w;
    logic [2*XLEN-1:0] rdata_w, head_w;
    logic [CW-1:0]    count_w;
    logic             full_w, empty_w;

    assign asel = a_sel_e'(bus.a_sel);
    assign bsel = b_sel_e'(bus.b_sel);

    assign in_ready_w = ~full_w;
    assign accept     = bus.in_valid & in_ready_w;
    assign is_cap     = (bsel == B_CAPTURE);
    assign hold_eff   = (hold_q == H_LOADED) ? hold_r_q : '0;

    always_comb begin
        an_c = '0;
        case (asel)
            A_RS1:     an_c = bus.rs1_i;
            A_PC:      an_c = bus.pc_i;
            A_ZERO:    an_c = '0;
            A_PC_NEXT: an_c = bus.pc_i + XLEN'(PC_STEP);
            default:   an_c = '0;
        endcase
    end

    // Capture and the reserved codes fall through to rs2; captures never reach the FIFO.
    always_comb begin
        am_c = bus.rs2_i;
        case (bsel)
            B_SEXT:   am_c = sext_imm(bus.imm_i);
            B_ZEXT:   am_c = zext_imm(bus.imm_i);
            B_TOP:    am_c = top_imm(bus.imm_i);
            B_CONCAT: am_c = top_imm(bus.imm_i) | zext_imm(hold_eff);
            default:  am_c = bus.rs2_i;
        endcase
    end

    always_comb begin
        hold_d   = hold_q;
        hold_r_d = hold_r_q;
        err_d    = err_q;
        if (accept) begin
            case (bsel)
                B_CAPTURE: begin
                    hold_d   = H_LOADED;
                    hold_r_d = bus.imm_i;
                end
                B_CONCAT: begin
                    if (hold_q == H_EMPTY) err_d = 1'b1;
                    hold_d = H_EMPTY;
                end
                B_RSV6, B_RSV7: err_d = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q   <= H_EMPTY;
            hold_r_q <= '0;
            err_q    <= 1'b0;
        end else begin
            hold_q   <= hold_d;
            hold_r_q <= hold_r_d;
            err_q    <= err_d;
        end
    end

`ifdef OPSTAGE_BYPASS_EN
    logic byp;
    assign byp         = empty_w & accept & ~is_cap;
    assign push        = accept & ~is_cap & ~(byp & bus.out_ready);
    assign out_valid_w = (count_w != '0) | byp;
    assign head_w      = empty_w ? {an_c, am_c} : rdata_w;
`else
    assign push        = accept & ~is_cap;
    assign out_valid_w = (count_w != '0);
    assign head_w      = rdata_w;
`endif

    assign pop = bus.out_ready & ~empty_w;

    opstage_fifo #(
        .DEPTH (OUT_DEPTH),
        .WIDTH (2*XLEN)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({an_c, am_c}),
        .rdata_o (rdata_w),
        .count_o (count_w),
        .full_o  (full_w),
        .empty_o (empty_w)
    );

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_w;
    assign bus.an_o      = out_valid_w ? head_w[2*XLEN-1:XLEN] : '0;
    assign bus.am_o      = out_valid_w ? head_w[XLEN-1:0] : '0;
    assign bus.err_o     = err_q;

endmodule

// File: tb/tb_operand_stage.sv
// Directed plus randomized bench for operand_stage against a queue-based model.
module tb_operand_stage;
    import opstage_pkg::*;

    localparam int DEPTH = 2;
`ifdef OPSTAGE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    opstage_if #(.XLEN(32), .IMM_W(16)) bus ();

    operand_stage #(.XLEN(32), .IMM_W(16), .OUT_DEPTH(DEPTH), .PC_STEP(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_chk = 0;
    int n_pass = 0;

    entry_t      mq[$];
    logic [31:0] popped[$];
    bit          m_loaded;
    logic [15:0] m_hold;
    bit          m_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h, want %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] ref_an(input logic [1:0] as, input logic [31:0] pc, input logic [31:0] r1);
        case (as)
            2'd0:    return r1;
            2'd1:    return pc;
            2'd2:    return 32'd0;
            default: return pc + 32'd4;
        endcase
    endfunction

    function automatic logic [31:0] ref_am(input logic [2:0] bs, input logic [31:0] r2, input logic [15:0] im);
        case (bs)
            3'd1:    return {{16{im[15]}}, im};
            3'd2:    return {16'h0000, im};
            3'd3:    return {im, 16'h0000};
            3'd4:    return {im, 16'h0000} | {16'h0000, (m_loaded ? m_hold : 16'h0000)};
            default: return r2;
        endcase
    endfunction

    // One clock of traffic: apply inputs, compare outputs with the model, advance both.
    task automatic drive(input bit v, input logic [1:0] as, input logic [2:0] bs,
                         input logic [31:0] pc, input logic [31:0] r1, input logic [31:0] r2,
                         input logic [15:0] im, input bit ordy);
        entry_t e, hd;
        bit acc, byp, ev;
        bus.in_valid = v;  bus.a_sel = as;  bus.b_sel = bs;
        bus.pc_i = pc;     bus.rs1_i = r1;  bus.rs2_i = r2;
        bus.imm_i = im;    bus.out_ready = ordy;
        #1;
        acc  = v && (mq.size() != DEPTH);
        byp  = BYP && (mq.size() == 0) && acc && (bs != 3'd5);
        e.an = ref_an(as, pc, r1);
        e.am = ref_am(bs, r2, im);
        ev   = (mq.size() != 0) || byp;
        hd   = (mq.size() != 0) ? mq[0] : (byp ? e : '0);
        check("in_ready", {31'd0, bus.in_ready}, {31'd0, mq.size() != DEPTH});
        check("out_valid", {31'd0, bus.out_valid}, {31'd0, ev});
        check("an_o", bus.an_o, hd.an);
        check("am_o", bus.am_o, hd.am);
        check("err_o", {31'd0, bus.err_o}, {31'd0, m_err});
        if (bus.out_valid && ordy) popped.push_back(bus.am_o);
        if (ev && ordy && mq.size() != 0) void'(mq.pop_front());
        if (acc) begin
            if (bs == 3'd5) begin
                m_loaded = 1'b1;
                m_hold   = im;
            end else begin
                if (bs >= 3'd6 || (bs == 3'd4 && !m_loaded)) m_err = 1'b1;
                if (bs == 3'd4) m_loaded = 1'b0;
                if (!(byp && ordy)) mq.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input bit ordy);
        drive(1'b0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 16'd0, ordy);
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst an_o", bus.an_o, 32'd0);
        check("rst am_o", bus.am_o, 32'd0);
        check("rst err_o", {31'd0, bus.err_o}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        mq.delete();
        m_loaded = 1'b0;
        m_hold   = 16'h0;
        m_err    = 1'b0;
        @(posedge clk);
        #1;
        check("post-rst in_ready", {31'd0, bus.in_ready}, 32'd1);
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.a_sel = 2'd0; bus.b_sel = 3'd0;
        bus.pc_i = '0; bus.rs1_i = '0; bus.rs2_i = '0; bus.imm_i = '0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Immediate placement with rs1 as A.
        drive(1, 2'd0, 3'd1, 32'h0, 32'h0000FFFF, 32'h0, 16'hABCD, 0);
        check("sext an", bus.an_o, 32'h0000FFFF);
        check("sext am", bus.am_o, 32'hFFFFABCD);
        idle(1);
        drive(1, 2'd0, 3'd2, 32'h0, 32'h0000FFFF, 32'h0, 16'hABCD, 0);
        check("zext am", bus.am_o, 32'h0000ABCD);
        idle(1);
        drive(1, 2'd0, 3'd3, 32'h0, 32'h0000FFFF, 32'h0, 16'hABCD, 0);
        check("top am", bus.am_o, 32'hABCD0000);
        idle(1);

        // Capture then concat, then a concat with nothing held.
        drive(1, 2'd0, 3'd5, 32'h0, 32'h0, 32'h0, 16'h5678, 0);
        check("capture no output", {31'd0, bus.out_valid}, 32'd0);
        drive(1, 2'd0, 3'd4, 32'h0, 32'h0, 32'h0, 16'h1234, 0);
        check("concat am", bus.am_o, 32'h12345678);
        check("concat err", {31'd0, bus.err_o}, 32'd0);
        idle(1);
        drive(1, 2'd0, 3'd4, 32'h0, 32'h0, 32'h0, 16'h1234, 0);
        check("empty concat am", bus.am_o, 32'h12340000);
        check("empty concat err", {31'd0, bus.err_o}, 32'd1);
        idle(1);

        // Backpressure: two fit, the third stalls until the head drains.
        popped.delete();
        drive(1, 2'd0, 3'd0, 32'h0, 32'h0, 32'd1, 16'h0, 0);
        drive(1, 2'd0, 3'd0, 32'h0, 32'h0, 32'd2, 16'h0, 0);
        check("full in_ready", {31'd0, bus.in_ready}, 32'd0);
        drive(1, 2'd0, 3'd0, 32'h0, 32'h0, 32'd3, 16'h0, 0);
        drive(1, 2'd0, 3'd0, 32'h0, 32'h0, 32'd3, 16'h0, 1);
        drive(1, 2'd0, 3'd0, 32'h0, 32'h0, 32'd3, 16'h0, 1);
        idle(1);
        idle(1);
        check("drain count", popped.size(), 32'd3);
        for (int i = 0; i < 3 && i < popped.size(); i++)
            check($sformatf("drain order %0d", i), popped[i], i + 1);

        // Latency through an empty FIFO.
        bus.in_valid = 1; bus.a_sel = 2'd0; bus.b_sel = 3'd0; bus.rs2_i = 32'd7; bus.out_ready = 1;
        #1;
`ifdef OPSTAGE_BYPASS_EN
        check("bypass same-cycle valid", {31'd0, bus.out_valid}, 32'd1);
        check("bypass same-cycle am", bus.am_o, 32'd7);
        drive(1, 2'd0, 3'd0, 32'h0, 32'h0, 32'd7, 16'h0, 1);
        check("bypass no entry", {31'd0, bus.out_valid}, 32'd0);
`else
        check("registered same-cycle valid", {31'd0, bus.out_valid}, 32'd0);
        drive(1, 2'd0, 3'd0, 32'h0, 32'h0, 32'd7, 16'h0, 1);
        check("registered next valid", {31'd0, bus.out_valid}, 32'd1);
        check("registered next am", bus.am_o, 32'd7);
        idle(1);
`endif

        for (int i = 0; i < 300; i++)
            drive(1'($urandom_range(0, 1)), 2'($urandom), 3'($urandom), $urandom, $urandom,
                  $urandom, 16'($urandom), 1'($urandom_range(0, 3) != 0));

        // Reset with a hold captured and two entries queued.
        idle(1);
        idle(1);
        drive(1, 2'd0, 3'd5, 32'h0, 32'h0, 32'h0, 16'h9999, 0);
        drive(1, 2'd0, 3'd0, 32'h0, 32'h0, $urandom, 16'h0, 0);
        drive(1, 2'd0, 3'd0, 32'h0, 32'h0, $urandom, 16'h0, 0);
        do_reset();
        drive(1, 2'd0, 3'd4, 32'h0, 32'h0, 32'h0, 16'h1234, 0);
        check("hold cleared am", bus.am_o, 32'h12340000);
        check("hold cleared err", {31'd0, bus.err_o}, 32'd1);
        do_reset();

        // PC sources and a reserved B code.
        drive(1, 2'd3, 3'd0, 32'hFFFFFFFC, 32'h0, 32'h0, 16'h0, 0);
        check("pc+step wrap", bus.an_o, 32'h00000000);
        idle(1);
        drive(1, 2'd1, 3'd0, 32'h00401000, 32'h0, 32'h0, 16'h0, 0);
        check("pc an", bus.an_o, 32'h00401000);
        idle(1);
        drive(1, 2'd0, 3'd6, 32'h0, 32'h0, 32'hCAFE0055, 16'h0, 0);
        check("reserved am", bus.am_o, 32'hCAFE0055);
        check("reserved err", {31'd0, bus.err_o}, 32'd1);
        idle(1);
        idle(1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
